// File: rtl/sub_pkg.sv
// sub_pkg: shared defaults, state encoding and index-width helper for the borrow-skip subtractor
package sub_pkg;
  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_BLOCK = 4;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/borrow_skip_block.sv
// borrow_skip_block: one combinational subtract slice with ripple borrow and propagate-skip mux
module borrow_skip_block #(
  parameter int BLOCK = 4
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             bin,
  output logic [BLOCK-1:0] d,
  output logic             bout,
  output logic             prop
);
  logic [BLOCK:0]   bw;
  logic [BLOCK-1:0] p;
  always_comb begin
    bw[0] = bin;
    for (int i = 0; i < BLOCK; i++) begin
      p[i]     = ~(a[i] ^ b[i]);
      d[i]     = a[i] ^ b[i] ^ bw[i];
      bw[i+1]  = (~a[i] & b[i]) | (p[i] & bw[i]);
    end
    prop = &p;
    bout = prop ? bin : bw[BLOCK];
  end
endmodule

// File: rtl/borrow_skip_sub_seq.sv
// borrow_skip_sub_seq: multi-cycle a - b - bin, one borrow-skip slice per cycle with valid/ready handshakes
module borrow_skip_sub_seq
  import sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int BLOCK = DEFAULT_BLOCK
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         a,
  input  logic [WIDTH-1:0]         b,
  input  logic                     bin,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         diff,
  output logic                     bout,
  output logic                     zero,
  output logic [WIDTH/BLOCK-1:0]   skip_mask
);
  localparam int NBLK = WIDTH / BLOCK;
  localparam int KW   = clog2(NBLK);
  state_t           state, state_nxt;
  logic [WIDTH-1:0] ra, rb, diff_nxt;
  logic             bw;
  logic [KW-1:0]    k;
  logic [BLOCK-1:0] sd;
  logic             sbout, sprop, last;
  borrow_skip_block #(.BLOCK(BLOCK)) u_blk (
    .a    (ra[k*BLOCK +: BLOCK]),
    .b    (rb[k*BLOCK +: BLOCK]),
    .bin  (bw),
    .d    (sd),
    .bout (sbout),
    .prop (sprop)
  );
  assign last      = k == KW'(NBLK - 1);
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  always_comb begin
    diff_nxt = diff;
    diff_nxt[k*BLOCK +: BLOCK] = sd;
    state_nxt = state == IDLE ? (in_valid ? RUN : IDLE) :
                state == RUN  ? (last ? DONE : RUN) :
                state == DONE ? (out_ready ? IDLE : DONE) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  // zero is taken from diff_nxt so it sees the final slice written this cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ra <= '0;
      rb <= '0;
      bw <= 1'b0;
      k <= '0;
      diff <= '0;
      skip_mask <= '0;
      bout <= 1'b0;
      zero <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      ra <= a;
      rb <= b;
      bw <= bin;
      k <= '0;
      diff <= '0;
      skip_mask <= '0;
    end else if (state == RUN) begin
      diff <= diff_nxt;
      skip_mask[k] <= sprop;
      bw <= sbout;
      k <= k + 1'b1;
      if (last) begin
        bout <= sbout;
        zero <= diff_nxt == '0;
      end
    end
  end
endmodule

// File: tb/tb_borrow_skip_sub_seq.sv
// tb_borrow_skip_sub_seq: directed vectors with a queue scoreboard checked by a separate output monitor
module tb_borrow_skip_sub_seq;
  typedef struct packed {
    logic [15:0] d;
    logic        bo;
    logic        z;
    logic [3:0]  m;
  } exp_t;
  logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1, bin = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        in_ready, out_valid, bout, zero;
  logic [15:0] diff;
  logic [3:0]  skip_mask;
  exp_t        q[$];
  int          applied = 0, miscompares = 0, cyc = 0, prev = 0;
  bit          gap_en = 1'b0, have_prev = 1'b0;

  borrow_skip_sub_seq #(.WIDTH(16), .BLOCK(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout), .zero(zero), .skip_mask(skip_mask)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        applied++;
        miscompares++;
        $display("FAIL unexpected_result: got diff %h with no expected entry", diff);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("diff", diff, e.d);
        chk("bout", bout, e.bo);
        chk("zero", zero, e.z);
        chk("skip_mask", skip_mask, e.m);
      end
      if (gap_en && have_prev) chk("issue_gap", cyc - prev, 6);
      prev = cyc;
      have_prev = 1'b1;
    end
  end

  task automatic issue(input logic [15:0] ia, input logic [15:0] ib, input logic ibin,
                       input exp_t e, input bit keep, input bit push);
    int n;
    @(negedge clk);
    a = ia;
    b = ib;
    bin = ibin;
    in_valid = 1'b1;
    if (push) q.push_back(e);
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_at_issue", in_ready, 1);
    @(posedge clk);
    #1 in_valid = keep;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", q.size(), 0);
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_diff"}, diff, 0);
    chk({tag, "_bout"}, bout, 0);
    chk({tag, "_zero"}, zero, 0);
    chk({tag, "_skip_mask"}, skip_mask, 0);
  endtask

  initial begin
    int n;
    #12 chk_reset_vals("reset");
    @(negedge clk) rst_n = 1'b1;
    // 1: accept-to-valid latency is NBLK cycles
    issue(16'h1234, 16'h0234, 1'b0, exp_t'{16'h1000, 1'b0, 1'b0, 4'b0111}, 1'b0, 1'b1);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1 n++;
    end
    chk("latency", n, 4);
    issue(16'h0000, 16'h0001, 1'b0, exp_t'{16'hFFFF, 1'b1, 1'b0, 4'b1110}, 1'b0, 1'b1);
    issue(16'hA5A5, 16'hA5A5, 1'b0, exp_t'{16'h0000, 1'b0, 1'b1, 4'b1111}, 1'b0, 1'b1);
    issue(16'hA5A5, 16'hA5A5, 1'b1, exp_t'{16'hFFFF, 1'b1, 1'b0, 4'b1111}, 1'b0, 1'b1);
    wait_drain();
    // 4: backpressure holds the result and blocks new operands
    @(posedge clk);
    #1 out_ready = 1'b0;
    issue(16'h8000, 16'h7FFF, 1'b0, exp_t'{16'h0001, 1'b0, 1'b0, 4'b0000}, 1'b0, 1'b1);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_diff", diff, 16'h0001);
      chk("hold_bout", bout, 0);
      chk("hold_zero", zero, 0);
      chk("hold_skip_mask", skip_mask, 0);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_out_valid", out_valid, 1);
      if (i == 1) begin
        a = 16'h1111;
        b = 16'h0000;
        in_valid = 1'b1;
      end else in_valid = 1'b0;
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait_drain();
    repeat (8) @(negedge clk);
    chk("no_ghost_result", out_valid, 0);
    // 5: asynchronous abort two cycles into RUN
    issue(16'hFFFF, 16'h0000, 1'b0, exp_t'('0), 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("abort");
    @(negedge clk) rst_n = 1'b1;
    issue(16'h0010, 16'h0001, 1'b0, exp_t'{16'h000F, 1'b0, 1'b0, 4'b1100}, 1'b0, 1'b1);
    wait_drain();
    // 6: back-to-back stream, one result every NBLK+2 cycles
    gap_en = 1'b1;
    have_prev = 1'b0;
    issue(16'hFFFF, 16'h0001, 1'b0, exp_t'{16'hFFFE, 1'b0, 1'b0, 4'b0000}, 1'b1, 1'b1);
    issue(16'h0005, 16'h0005, 1'b1, exp_t'{16'hFFFF, 1'b1, 1'b0, 4'b1111}, 1'b1, 1'b1);
    issue(16'h1000, 16'h2000, 1'b0, exp_t'{16'hF000, 1'b1, 1'b0, 4'b0111}, 1'b1, 1'b1);
    issue(16'h00FF, 16'h00FF, 1'b0, exp_t'{16'h0000, 1'b0, 1'b1, 4'b1111}, 1'b0, 1'b1);
    wait_drain();
    gap_en = 1'b0;
    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
